// File: rtl/player_motion_ctl.sv
// player_motion_ctl: owns the player X/Y position; applies walk, jump and gravity once per frame,
// moving one pixel per clock so equality-based collision checks never skip a pixel.
// Latency: 1 + dx_taken + dy_taken + 1 clks from frame_tick to busy=0; frame_tick while busy is dropped (overrun).
// Ports: clk, rst (async, active-high), frame_tick, btn_left/btn_right/btn_jump (levels sampled at frame start),
//   coll (collision code for the current x_pos/y_pos: 11 side, 10 landed, 01 hit from below, 00 none),
//   x_pos/y_pos (registered position), airborne (JUMP or FALL), busy (frame sub-steps pending), overrun (sticky).
// Optional feature: define DOUBLE_JUMP_EN to allow one extra jump while airborne.
module player_motion_ctl #(
  parameter int X_INIT      = 100,
  parameter int Y_INIT      = 703,
  parameter int WIDTH       = 48,
  parameter int HEIGHT      = 64,
  parameter int STEP_X      = 3,
  parameter int JUMP_V0     = 12,
  parameter int V_MAX       = 10,
  parameter int GRAVITY_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic [1:0] coll,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       airborne,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {GROUND, JUMP, FALL} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [9:0] FLOOR_Y = 10'(767 - HEIGHT);
  localparam logic [9:0] X_MAX   = 10'(1023 - WIDTH);
  localparam logic [9:0] X0      = 10'(X_INIT);
  localparam logic [9:0] Y0      = 10'(Y_INIT);
  localparam logic [3:0] STEP    = 4'(STEP_X);
  localparam logic [3:0] V0      = 4'(JUMP_V0);
  localparam logic [3:0] VMAX    = 4'(V_MAX);
  localparam logic [3:0] GC_LAST = 4'(GRAVITY_DIV - 1);

  state_t     state, state_n;
  dir_t       h_dir, h_dir_n, blocked, blocked_n;
  logic [3:0] vel, vel_n, dx, dx_n, dy, dy_n, gc, gc_n;
  logic [9:0] x_n, y_n;
  logic       busy_n, overrun_n, last_h, last_h_n, jump_l, jump_l_n;
  logic       h_room, frame_end, trans;
`ifdef DOUBLE_JUMP_EN
  logic       armed, armed_n, jump_prev, jump_prev_n;
`endif

  assign airborne = (state != GROUND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= GROUND;
      h_dir   <= DIR_NONE;
      blocked <= DIR_NONE;
      vel     <= '0;
      dx      <= '0;
      dy      <= '0;
      gc      <= '0;
      x_pos   <= X0;
      y_pos   <= Y0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      last_h  <= 1'b0;
      jump_l  <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      armed     <= 1'b1;
      jump_prev <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      h_dir   <= h_dir_n;
      blocked <= blocked_n;
      vel     <= vel_n;
      dx      <= dx_n;
      dy      <= dy_n;
      gc      <= gc_n;
      x_pos   <= x_n;
      y_pos   <= y_n;
      busy    <= busy_n;
      overrun <= overrun_n;
      last_h  <= last_h_n;
      jump_l  <= jump_l_n;
`ifdef DOUBLE_JUMP_EN
      armed     <= armed_n;
      jump_prev <= jump_prev_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    h_dir_n   = h_dir;
    blocked_n = blocked;
    vel_n     = vel;
    dx_n      = dx;
    dy_n      = dy;
    gc_n      = gc;
    x_n       = x_pos;
    y_n       = y_pos;
    busy_n    = busy;
    overrun_n = overrun;
    last_h_n  = last_h;
    jump_l_n  = jump_l;
    frame_end = 1'b0;
    trans     = 1'b0;
`ifdef DOUBLE_JUMP_EN
    armed_n     = armed;
    jump_prev_n = jump_prev;
`endif

    // A horizontal step is only taken if it keeps X inside 1..X_MAX.
    case (h_dir)
      DIR_RIGHT: h_room = (x_pos < X_MAX);
      DIR_LEFT:  h_room = (x_pos > 10'd1);
      default:   h_room = 1'b0;
    endcase

    if (!busy) begin
      if (frame_tick) begin
        busy_n   = 1'b1;
        dx_n     = STEP;
        dy_n     = vel;
        last_h_n = 1'b0;
        jump_l_n = btn_jump;
        h_dir_n  = (btn_left && !btn_right) ? DIR_LEFT :
                   (btn_right && !btn_left) ? DIR_RIGHT : DIR_NONE;
`ifdef DOUBLE_JUMP_EN
        jump_prev_n = btn_jump;
        if (state != GROUND && armed && btn_jump && !jump_prev) begin
          state_n = JUMP;
          vel_n   = V0;
          gc_n    = '0;
          dy_n    = '0;
          armed_n = 1'b0;
        end
`endif
      end
    end else begin
      overrun_n = overrun | frame_tick;
      last_h_n  = 1'b0;
      // coll reflects the position reached by the previous clock's step.
      if (last_h && coll == 2'b11) begin
        blocked_n = h_dir;
        dx_n      = '0;
      end
      // Horizontal sub-steps first; once none remain, each clock does vertical work or ends the frame.
      if (dx_n != 4'd0 && h_room && h_dir != blocked_n) begin
        x_n       = (h_dir == DIR_RIGHT) ? x_pos + 10'd1 : x_pos - 10'd1;
        dx_n      = dx_n - 4'd1;
        last_h_n  = 1'b1;
        blocked_n = DIR_NONE;  // only reachable when stepping away from the block
      end else begin
        case (state)
          GROUND: begin
            frame_end = 1'b1;
            if (jump_l && coll != 2'b01) begin
              state_n = JUMP;
              vel_n   = V0;
              gc_n    = '0;
              trans   = 1'b1;
            end else if (!coll[1] && y_pos != FLOOR_Y) begin
              state_n = FALL;
              vel_n   = 4'd1;
              gc_n    = '0;
              trans   = 1'b1;
            end
          end
          JUMP: begin
            if (coll == 2'b01 || y_pos == 10'd1) begin
              state_n   = FALL;
              vel_n     = 4'd1;
              gc_n      = '0;
              trans     = 1'b1;
              frame_end = 1'b1;
            end else if (dy != 4'd0) begin
              y_n  = y_pos - 10'd1;
              dy_n = dy - 4'd1;
            end else begin
              frame_end = 1'b1;
            end
          end
          FALL: begin
            // A side code right after a horizontal step is a wall, not a platform top.
            if (coll == 2'b10 || (coll == 2'b11 && !last_h) || y_pos == FLOOR_Y) begin
              state_n   = GROUND;
              vel_n     = '0;
              gc_n      = '0;
              trans     = 1'b1;
              frame_end = 1'b1;
            end else if (dy != 4'd0) begin
              y_n  = y_pos + 10'd1;
              dy_n = dy - 4'd1;
            end else begin
              frame_end = 1'b1;
            end
          end
          default: frame_end = 1'b1;
        endcase
      end

      if (frame_end) begin
        busy_n = 1'b0;
        dx_n   = '0;
        dy_n   = '0;
        // A state change this frame already restarted the gravity counter.
        if (!trans) begin
          if (gc == GC_LAST) begin
            gc_n = '0;
            if (state == JUMP) begin
              if (vel <= 4'd1) begin
                state_n = FALL;
                vel_n   = 4'd1;
              end else begin
                vel_n = vel - 4'd1;
              end
            end else if (state == FALL && vel < VMAX) begin
              vel_n = vel + 4'd1;
            end
          end else begin
            gc_n = gc + 4'd1;
          end
        end
      end
    end

    if (state_n != state) blocked_n = DIR_NONE;
`ifdef DOUBLE_JUMP_EN
    if (state_n == GROUND && state != GROUND) armed_n = 1'b1;
`endif
  end

endmodule

// File: tb/tb_player_motion_ctl.sv
// Bench for player_motion_ctl: per-frame vectors with a scoreboard queue, plus hand sequences
// for airborne settling, overrun, mid-frame reset and the left X bound.
module tb_player_motion_ctl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0;
  logic [1:0] coll;
  logic [9:0] x_pos, y_pos;
  logic       airborne, busy, overrun;
  int         coll_mode = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  player_motion_ctl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
    .coll(coll), .x_pos(x_pos), .y_pos(y_pos),
    .airborne(airborne), .busy(busy), .overrun(overrun)
  );

  // Collision world: a combinational function of the registered position.
  always_comb begin
    coll = 2'b00;
    case (coll_mode)
      1: if (x_pos == 10'd106) coll = 2'b11;
      2: if (y_pos == 10'd650) coll = 2'b01;
      3: if (y_pos == 10'd560) coll = 2'b10;
      4: if (y_pos == 10'd500) coll = 2'b10;
      5: if (x_pos == 10'd105) coll = 2'b11;
      default: coll = 2'b00;
    endcase
  end

  typedef struct {
    logic l, r, j;
    int   mode;
    int   x, y;
    logic air;
    int   clks;
    bit   settle;
    int   land_y, min_y, max_fall;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic l, logic r, logic j, int m, int x, int y, logic air, int clks,
                              bit st = 1'b0, int ly = 0, int mn = 0, int mf = 0);
    vec_t v;
    v.l = l; v.r = r; v.j = j; v.mode = m; v.x = x; v.y = y; v.air = air; v.clks = clks;
    v.settle = st; v.land_y = ly; v.min_y = mn; v.max_fall = mf;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One frame: pulse frame_tick, then count clocks while busy (bounded).
  task automatic do_frame(input logic l, input logic r, input logic j, input int m, output int clks);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_jump = j; coll_mode = m; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    clks = 0;
    while (busy && clks < 100) begin
      @(negedge clk);
      clks++;
    end
  endtask

  // Run idle frames until grounded; check landing Y, highest point and largest per-frame drop.
  task automatic settle(input int m, input int land_y, input int min_y, input int max_fall, input string tag);
    int c, prev, mn, mx, n;
    mn = 1024; mx = 0; n = 0; prev = int'(y_pos);
    while (airborne && n < 300) begin
      do_frame(1'b0, 1'b0, 1'b0, m, c);
      n++;
      if (int'(y_pos) < mn) mn = int'(y_pos);
      if (int'(y_pos) - prev > mx) mx = int'(y_pos) - prev;
      prev = int'(y_pos);
    end
    check({tag, " landed"}, int'(airborne), 0);
    check({tag, " land_y"}, int'(y_pos), land_y);
    check({tag, " apex"}, mn, min_y);
    check({tag, " max_fall"}, mx, max_fall);
  endtask

  task automatic frame_check(input vec_t v, input string tag);
    vec_t e;
    int   c;
    sb.push_back(v);
    do_frame(v.l, v.r, v.j, v.mode, c);
    e = sb.pop_front();
    check({tag, " x"}, int'(x_pos), e.x);
    check({tag, " y"}, int'(y_pos), e.y);
    check({tag, " airborne"}, int'(airborne), int'(e.air));
    check({tag, " busy_clks"}, c, e.clks);
    if (e.settle) settle(e.mode, e.land_y, e.min_y, e.max_fall, tag);
  endtask

  initial begin
    int c;
    // walk right, then back left
    tbl.push_back(mk(0,1,0,0,103,703,0,4));
    tbl.push_back(mk(0,1,0,0,106,703,0,4));
    tbl.push_back(mk(0,1,0,0,109,703,0,4));
    tbl.push_back(mk(0,1,0,0,112,703,0,4));
    tbl.push_back(mk(0,1,0,0,115,703,0,4));
    tbl.push_back(mk(1,0,0,0,112,703,0,4));
    tbl.push_back(mk(1,0,0,0,109,703,0,4));
    tbl.push_back(mk(1,0,0,0,106,703,0,4));
    tbl.push_back(mk(1,0,0,0,103,703,0,4));
    // side wall at 106: block, refuse, clear by stepping away
    tbl.push_back(mk(0,1,0,1,106,703,0,4));
    tbl.push_back(mk(0,1,0,1,106,703,0,1));
    tbl.push_back(mk(1,0,0,1,103,703,0,4));
    // wall at 105 hit mid-frame drops the remaining step
    tbl.push_back(mk(0,1,0,5,105,703,0,3));
    tbl.push_back(mk(0,1,0,5,105,703,0,1));
    tbl.push_back(mk(1,0,0,0,102,703,0,4));
    tbl.push_back(mk(0,1,0,0,105,703,0,4));
    tbl.push_back(mk(1,1,0,0,105,703,0,1));
    // full jump from the floor
    tbl.push_back(mk(0,0,1,0,105,703,1,1));
    tbl.push_back(mk(0,0,0,0,105,691,1,13));
    tbl.push_back(mk(0,0,0,0,105,679,1,13));
    tbl.push_back(mk(0,0,0,0,105,667,1,13));
    tbl.push_back(mk(0,0,0,0,105,655,1,13));
    tbl.push_back(mk(0,0,0,0,105,644,1,12, 1'b1, 703, 391, 10));
    // ceiling hit at 650
    tbl.push_back(mk(0,0,1,2,105,703,1,1));
    tbl.push_back(mk(0,0,0,2,105,691,1,13));
    tbl.push_back(mk(0,0,0,2,105,679,1,13));
    tbl.push_back(mk(0,0,0,2,105,667,1,13));
    tbl.push_back(mk(0,0,0,2,105,655,1,13));
    tbl.push_back(mk(0,0,0,2,105,650,1,6));
    tbl.push_back(mk(0,0,0,2,105,651,1,2));
    tbl.push_back(mk(0,0,0,2,105,652,1,2));
    tbl.push_back(mk(0,0,0,2,105,653,1,2));
    tbl.push_back(mk(0,0,0,2,105,654,1,2));
    tbl.push_back(mk(0,0,0,2,105,656,1,3, 1'b1, 703, 658, 5));
    // land on a platform at 500, then the platform is removed
    tbl.push_back(mk(0,0,1,4,105,703,1,1, 1'b1, 500, 391, 7));
    tbl.push_back(mk(0,0,0,4,105,500,0,1));
    tbl.push_back(mk(0,0,0,3,105,500,1,1));
    tbl.push_back(mk(0,0,0,3,105,501,1,2));
    tbl.push_back(mk(0,0,0,3,105,502,1,2));
    tbl.push_back(mk(0,0,0,3,105,503,1,2));
    tbl.push_back(mk(0,0,0,3,105,504,1,2));
    tbl.push_back(mk(0,0,0,3,105,506,1,3));
    tbl.push_back(mk(0,0,0,3,105,508,1,3));
    tbl.push_back(mk(0,0,0,3,105,510,1,3));
    tbl.push_back(mk(0,0,0,3,105,512,1,3, 1'b1, 560, 515, 5));

    // reset state
    repeat (2) @(negedge clk);
    check("reset x", int'(x_pos), 100);
    check("reset y", int'(y_pos), 703);
    check("reset airborne", int'(airborne), 0);
    check("reset busy", int'(busy), 0);
    check("reset overrun", int'(overrun), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) frame_check(tbl[i], $sformatf("v%0d", i));

    // second tick two clocks into a frame: ignored and flagged
    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b1; btn_jump = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    c = 0;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
    check("overrun flag", int'(overrun), 1);
    check("overrun x", int'(x_pos), 108);
    check("overrun busy", int'(busy), 0);
    frame_check(mk(0,1,0,3,111,560,0,4), "after_overrun");
    check("overrun sticky", int'(overrun), 1);

    // reset in the middle of a frame
    @(negedge clk);
    btn_right = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst x", int'(x_pos), 100);
    check("midrst y", int'(y_pos), 703);
    check("midrst busy", int'(busy), 0);
    check("midrst overrun", int'(overrun), 0);
    check("midrst airborne", int'(airborne), 0);
    @(negedge clk);
    rst = 1'b0;

    // walk to the left bound
    for (int k = 0; k < 33; k++) frame_check(mk(1,0,0,0,97 - 3 * k,703,0,4), $sformatf("left%0d", k));
    frame_check(mk(1,0,0,0,1,703,0,1), "left_bound");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
